// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: letter one-hot codes, key-controller FSM encoding,
// default notch/debounce constants and small 5-bit rotor helpers.
package enigma_pkg;

  localparam int LETTERS = 26;

  localparam logic [25:0] A = 26'h0000001;
  localparam logic [25:0] B = 26'h0000002;
  localparam logic [25:0] C = 26'h0000004;
  localparam logic [25:0] D = 26'h0000008;
  localparam logic [25:0] E = 26'h0000010;
  localparam logic [25:0] F = 26'h0000020;
  localparam logic [25:0] G = 26'h0000040;
  localparam logic [25:0] H = 26'h0000080;
  localparam logic [25:0] I = 26'h0000100;
  localparam logic [25:0] J = 26'h0000200;
  localparam logic [25:0] K = 26'h0000400;
  localparam logic [25:0] L = 26'h0000800;
  localparam logic [25:0] M = 26'h0001000;
  localparam logic [25:0] N = 26'h0002000;
  localparam logic [25:0] O = 26'h0004000;
  localparam logic [25:0] P = 26'h0008000;
  localparam logic [25:0] Q = 26'h0010000;
  localparam logic [25:0] R = 26'h0020000;
  localparam logic [25:0] S = 26'h0040000;
  localparam logic [25:0] T = 26'h0080000;
  localparam logic [25:0] U = 26'h0100000;
  localparam logic [25:0] V = 26'h0200000;
  localparam logic [25:0] W = 26'h0400000;
  localparam logic [25:0] X = 26'h0800000;
  localparam logic [25:0] Y = 26'h1000000;
  localparam logic [25:0] Z = 26'h2000000;

  // Index -> lamp/key code table, entry 0 is A.
  localparam logic [LETTERS-1:0][25:0] LETTER_LUT = {
    Z, Y, X, W, V, U, T, S, R, Q, P, O, N, M, L, K, J, I, H, G, F, E, D, C, B, A
  };

  localparam int          DEBOUNCE_CYCLES_DEF = 250000;
  localparam logic [4:0]  NOTCH_R_DEF         = 5'd21;
  localparam logic [4:0]  NOTCH_M_DEF         = 5'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_STEP,
    S_REQ,
    S_HOLD,
    S_RELEASE
  } key_state_e;

  function automatic logic [4:0] wrap_inc(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  // Inputs are at most 31, so one conditional subtract reduces mod 26.
  function automatic logic [4:0] mod26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  function automatic logic [25:0] letter_onehot(input logic [4:0] idx);
    logic [25:0] r;
    r = '0;
    if (idx < 5'd26) r = LETTER_LUT[idx];
    return r;
  endfunction

endpackage

// File: rtl/onehot26_enc.sv
// 26-bit one-hot to 5-bit index; valid only when exactly one bit is set.
module onehot26_enc (
  input  logic [25:0] onehot_i,
  output logic [4:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 26; i++) begin
      if (onehot_i[i]) idx_o = idx_o | 5'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 26'd1)) == '0);

endmodule

// File: rtl/enigma_key_ctrl.sv
// Enigma keypress front end: debounce, rotor stepping with double step,
// req/ack hand-off to the cipher core, and lamp/rotor outputs for the gui.
module enigma_key_ctrl
  import enigma_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [4:0] NOTCH_R         = NOTCH_R_DEF,
  parameter logic [4:0] NOTCH_M         = NOTCH_M_DEF
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [25:0] key,
  input  logic        pos_load,
  input  logic [4:0]  pos_init1,
  input  logic [4:0]  pos_init2,
  input  logic [4:0]  pos_init3,
  output logic        enc_req,
  output logic [4:0]  enc_in,
  input  logic        enc_ack,
  input  logic [4:0]  enc_out,
  output logic [25:0] lamp,
  output logic [4:0]  state1,
  output logic [4:0]  state2,
  output logic [4:0]  state3,
  output logic        busy,
  output logic        err
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [25:0]       key_q, key_d;
  logic [4:0]        key_idx_q, key_idx_d;
  logic [4:0]        enc_in_q, enc_in_d;
  logic [4:0]        enc_out_q, enc_out_d;
  logic [25:0]       lamp_q, lamp_d;
  logic [4:0]        pos1_q, pos1_d;
  logic [4:0]        pos2_q, pos2_d;
  logic [4:0]        pos3_q, pos3_d;
  logic              err_q, err_d;

  logic [4:0]        key_idx;
  logic              key_valid;
  logic              mid_step;
  logic              left_step;

  onehot26_enc u_key_enc (
    .onehot_i (key),
    .idx_o    (key_idx),
    .valid_o  (key_valid)
  );

  // Both step decisions look at pre-step positions: this is the double step.
  assign left_step = (pos2_q == NOTCH_M);
  assign mid_step  = (pos1_q == NOTCH_R) | left_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_idx_d = key_idx_q;
    enc_in_d  = enc_in_q;
    enc_out_d = enc_out_q;
    lamp_d    = lamp_q;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    pos3_d    = pos3_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (pos_load) begin
          pos1_d = mod26(pos_init1);
          pos2_d = mod26(pos_init2);
          pos3_d = mod26(pos_init3);
        end else if (key_valid) begin
          key_d     = key;
          key_idx_d = key_idx;
          cnt_d     = CNT_ONE;
          state_d   = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (key != key_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q >= CNT_LAST) state_d = S_STEP;
        end
      end
      S_STEP: begin
        pos1_d = wrap_inc(pos1_q);
        if (mid_step)  pos2_d = wrap_inc(pos2_q);
        if (left_step) pos3_d = wrap_inc(pos3_q);
        enc_in_d = key_idx_q;
        state_d  = S_REQ;
      end
      S_REQ: begin
        if (enc_ack) begin
          enc_out_d = enc_out;
          lamp_d    = letter_onehot(enc_out);
          if (enc_out > 5'd25) err_d = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        lamp_d = letter_onehot(enc_out_q);
        if (enc_out_q > 5'd25) err_d = 1'b1;
        if (key == '0) begin
          cnt_d   = CNT_ONE;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Any key activity restarts the release window.
        if (key == '0) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q >= CNT_LAST) begin
            lamp_d  = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      key_idx_q <= '0;
      enc_in_q  <= '0;
      enc_out_q <= '0;
      lamp_q    <= '0;
      pos1_q    <= '0;
      pos2_q    <= '0;
      pos3_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      key_idx_q <= key_idx_d;
      enc_in_q  <= enc_in_d;
      enc_out_q <= enc_out_d;
      lamp_q    <= lamp_d;
      pos1_q    <= pos1_d;
      pos2_q    <= pos2_d;
      pos3_q    <= pos3_d;
      err_q     <= err_d;
    end
  end

  assign enc_req = (state_q == S_REQ);
  assign busy    = (state_q != S_IDLE);
  assign enc_in  = enc_in_q;
  assign lamp    = lamp_q;
  assign state1  = pos1_q;
  assign state2  = pos2_q;
  assign state3  = pos3_q;
  assign err     = err_q;

endmodule

// File: tb/tb_enigma_key_ctrl.sv
// Self-checking bench for enigma_key_ctrl with a short debounce window;
// expected encode transactions are queued at press time and checked at enc_req.
module tb_enigma_key_ctrl;

  localparam int DEB = 4;

  logic        CLOCK_50;
  logic        resetn;
  logic [25:0] key;
  logic        pos_load;
  logic [4:0]  pos_init1, pos_init2, pos_init3;
  logic        enc_req;
  logic [4:0]  enc_in;
  logic        enc_ack;
  logic [4:0]  enc_out;
  logic [25:0] lamp;
  logic [4:0]  state1, state2, state3;
  logic        busy;
  logic        err;

  int tests;
  int failed;

  typedef struct {
    logic [4:0]  enc_in;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  s3;
    logic [25:0] lamp;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  enigma_key_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .key       (key),
    .pos_load  (pos_load),
    .pos_init1 (pos_init1),
    .pos_init2 (pos_init2),
    .pos_init3 (pos_init3),
    .enc_req   (enc_req),
    .enc_in    (enc_in),
    .enc_ack   (enc_ack),
    .enc_out   (enc_out),
    .lamp      (lamp),
    .state1    (state1),
    .state2    (state2),
    .state3    (state3),
    .busy      (busy),
    .err       (err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic load_pos(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    pos_load = 1'b1;
    pos_init1 = p1;
    pos_init2 = p2;
    pos_init3 = p3;
    tick();
    pos_load = 1'b0;
  endtask

  // Press, answer the request two cycles after enc_req, then release.
  task automatic press_and_release(input string tag, input logic [25:0] k,
                                   input logic [4:0] eout, input bit check_lat);
    exp_t e;
    int   lat;
    int   held;
    bit   got;
    key = k;
    got = 0;
    lat = 0;
    while (!got && lat < 50) begin
      tick();
      lat++;
      if (enc_req === 1'b1) got = 1;
    end
    tests++;
    if (!got) begin
      failed++;
      $display("FAIL %s_req: enc_req=%b after %0d cycles, required 1", tag, enc_req, lat);
      key = '0;
      wait_idle(tag);
      return;
    end
    if (check_lat) begin
      tests++;
      if (lat != DEB + 1) begin
        failed++;
        $display("FAIL %s_latency: enc_req after %0d cycles, required %0d", tag, lat, DEB + 1);
      end
    end
    tests++;
    if (sb_q.size() == 0) begin
      failed++;
      $display("FAIL %s_scoreboard: no expected entry queued, required 1", tag);
      key = '0;
      wait_idle(tag);
      return;
    end
    e = sb_q.pop_front();
    tests++;
    if (enc_in !== e.enc_in) begin
      failed++; $display("FAIL %s_enc_in: got %0d, required %0d", tag, enc_in, e.enc_in);
    end
    tests++;
    if ({state1, state2, state3} !== {e.s1, e.s2, e.s3}) begin
      failed++;
      $display("FAIL %s_rotors: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
               tag, state1, state2, state3, e.s1, e.s2, e.s3);
    end
    tick();
    tick();
    tests++;
    if (enc_req !== 1'b1 || enc_in !== e.enc_in) begin
      failed++;
      $display("FAIL %s_req_hold: enc_req=%b enc_in=%0d, required 1 and %0d", tag, enc_req, enc_in, e.enc_in);
    end
    enc_ack = 1'b1;
    enc_out = eout;
    tick();
    enc_ack = 1'b0;
    enc_out = '0;
    held = lat + 3;
    tests++;
    if (enc_req !== 1'b0) begin
      failed++; $display("FAIL %s_req_drop: enc_req=%b, required 0", tag, enc_req);
    end
    tests++;
    if (lamp !== e.lamp) begin
      failed++; $display("FAIL %s_lamp: got %h, required %h", tag, lamp, e.lamp);
    end
    tests++;
    if (err !== e.err) begin
      failed++; $display("FAIL %s_err: got %b, required %b", tag, err, e.err);
    end
    // Neither a load request nor a different letter may disturb the held press.
    pos_load = 1'b1;
    pos_init1 = 5'd9; pos_init2 = 5'd9; pos_init3 = 5'd9;
    key = 26'h0000100;
    tick();
    held++;
    pos_load = 1'b0;
    key = k;
    tests++;
    if ({state1, state2, state3} !== {e.s1, e.s2, e.s3} || lamp !== e.lamp || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s_hold_ignore: rotors (%0d,%0d,%0d) lamp %h busy %b, required (%0d,%0d,%0d) %h 1",
               tag, state1, state2, state3, lamp, busy, e.s1, e.s2, e.s3, e.lamp);
    end
    while (held < 12) begin
      tick();
      held++;
    end
    key = '0;
    tick(); tick(); tick();
    tests++;
    if (lamp !== e.lamp || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s_release_early: lamp %h busy %b, required %h 1", tag, lamp, busy, e.lamp);
    end
    tick();
    tests++;
    if (lamp !== 26'h0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_release: lamp %h busy %b, required 0 0", tag, lamp, busy);
    end
    $display("[TB] %s key=%h enc_in=%0d rotors=(%0d,%0d,%0d) lamp=%h err=%b",
             tag, k, e.enc_in, e.s1, e.s2, e.s3, e.lamp, e.err);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    tests++;
    if (lamp !== 26'h0) begin failed++; $display("FAIL reset_lamp: got %h, required 0", lamp); end
    tests++;
    if ({state1, state2, state3} !== 15'h0) begin
      failed++; $display("FAIL reset_rotors: got (%0d,%0d,%0d), required (0,0,0)", state1, state2, state3);
    end
    tests++;
    if (enc_req !== 1'b0) begin failed++; $display("FAIL reset_enc_req: got %b, required 0", enc_req); end
    tests++;
    if (enc_in !== 5'd0) begin failed++; $display("FAIL reset_enc_in: got %0d, required 0", enc_in); end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++;
    if (err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b, required 0", err); end
    resetn = 1'b1;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_basic_press();
    sb_q.push_back('{5'd0, 5'd1, 5'd0, 5'd0, 26'h0000002, 1'b0});
    press_and_release("basic", 26'h0000001, 5'd1, 1'b1);
  endtask

  task automatic test_load_mod();
    load_pos(5'd27, 5'd31, 5'd26);
    tests++;
    if ({state1, state2, state3} !== {5'd1, 5'd5, 5'd0}) begin
      failed++;
      $display("FAIL load_mod26: got (%0d,%0d,%0d), required (1,5,0)", state1, state2, state3);
    end
    $display("[TB] load (27,31,26) -> (%0d,%0d,%0d)", state1, state2, state3);
  endtask

  task automatic test_double_step();
    load_pos(5'd21, 5'd3, 5'd0);
    sb_q.push_back('{5'd1, 5'd22, 5'd4, 5'd0, 26'h0000080, 1'b0});
    press_and_release("dstep1", 26'h0000002, 5'd7, 1'b0);
    sb_q.push_back('{5'd25, 5'd23, 5'd5, 5'd1, 26'h2000000, 1'b0});
    press_and_release("dstep2", 26'h2000000, 5'd25, 1'b0);
  endtask

  task automatic test_wrap();
    load_pos(5'd25, 5'd0, 5'd0);
    sb_q.push_back('{5'd12, 5'd0, 5'd0, 5'd0, 26'h0000001, 1'b0});
    press_and_release("wrap", 26'h0001000, 5'd0, 1'b0);
  endtask

  task automatic test_bounce_invalid();
    int req_seen;
    int busy_seen;
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      key = (i % 2 == 0) ? 26'h0000001 : 26'h0;
      for (int j = 0; j < 2; j++) begin
        tick();
        if (enc_req === 1'b1) req_seen++;
      end
    end
    key = '0;
    for (int j = 0; j < DEB + 2; j++) begin
      tick();
      if (enc_req === 1'b1) req_seen++;
    end
    tests++;
    if (req_seen != 0) begin
      failed++; $display("FAIL bounce: enc_req high %0d cycles, required 0", req_seen);
    end
    $display("[TB] bounce enc_req_cycles=%0d", req_seen);
    req_seen = 0;
    busy_seen = 0;
    key = 26'h0000003;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (enc_req === 1'b1) req_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    key = '0;
    tests++;
    if (req_seen != 0 || busy_seen != 0) begin
      failed++;
      $display("FAIL multihot: enc_req %0d busy %0d cycles, required 0 0", req_seen, busy_seen);
    end
    $display("[TB] multihot enc_req_cycles=%0d busy_cycles=%0d", req_seen, busy_seen);
  endtask

  task automatic test_reset_mid_handshake();
    int n;
    load_pos(5'd5, 5'd6, 5'd7);
    key = 26'h0000010;
    n = 0;
    while (enc_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (enc_req !== 1'b1) begin
      failed++; $display("FAIL midreset_req: enc_req=%b after %0d cycles, required 1", enc_req, n);
    end
    resetn = 1'b0;
    tick();
    tests++;
    if (enc_req !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL midreset_req_drop: enc_req %b busy %b, required 0 0", enc_req, busy);
    end
    tests++;
    if ({state1, state2, state3} !== 15'h0) begin
      failed++;
      $display("FAIL midreset_rotors: got (%0d,%0d,%0d), required (0,0,0)", state1, state2, state3);
    end
    key = '0;
    resetn = 1'b1;
    tick();
    $display("[TB] reset during enc_req -> enc_req=%b rotors=(%0d,%0d,%0d)", enc_req, state1, state2, state3);
  endtask

  task automatic test_bad_encode();
    sb_q.push_back('{5'd2, 5'd1, 5'd0, 5'd0, 26'h0, 1'b1});
    press_and_release("badenc", 26'h0000004, 5'd26, 1'b0);
    tests++;
    if (err !== 1'b1) begin failed++; $display("FAIL err_sticky: got %b, required 1", err); end
    sb_q.push_back('{5'd0, 5'd2, 5'd0, 5'd0, 26'h0000008, 1'b1});
    press_and_release("after_err", 26'h0000001, 5'd3, 1'b0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    resetn = 1'b0;
    key = '0;
    pos_load = 1'b0;
    pos_init1 = '0;
    pos_init2 = '0;
    pos_init3 = '0;
    enc_ack = 1'b0;
    enc_out = '0;
    test_reset();
    test_basic_press();
    test_load_mod();
    test_double_step();
    test_wrap();
    test_bounce_invalid();
    test_reset_mid_handshake();
    test_bad_encode();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
